// File: rtl/out_mem_pkg.sv
// Shared output-memory-path types and default bus widths (also used by write_memory_controller).
// Pure declarations: no latency, no flow control.
package out_mem_pkg;

    localparam int ADD_SIZE_DEF  = 11;
    localparam int DATA_SIZE_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        ISSUE,
        WAIT_ACK,
        DONE
    } seq_state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with registered count, head visible the cycle after the push.
// Push ignored when full, pop ignored when empty; flush empties it in one cycle.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_write_sequencer.sv
// Buffers result words and writes them one at a time to sequential frame addresses; push-to-ISSUE is 2 cycles.
// res_ready drops when not busy or the FIFO is full; each word waits for wr_out_ready under a watchdog.
module result_write_sequencer
    import out_mem_pkg::*;
#(
    parameter int ADD_SIZE       = ADD_SIZE_DEF,
    parameter int DATA_SIZE      = DATA_SIZE_DEF,
    parameter int FIFO_DEPTH     = 4,
    parameter int FRAME_WORDS    = 1024,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADD_SIZE-1:0]  base_addr,
    input  logic                 res_valid,
    input  logic [DATA_SIZE-1:0] res_data,
    output logic                 res_ready,
    output logic                 wr_in_valid,
    output logic                 wr_write_en,
    output logic [ADD_SIZE-1:0]  wr_address,
    output logic [DATA_SIZE-1:0] wr_data,
    input  logic                 wr_out_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout_err,
    output logic [ADD_SIZE:0]    word_count
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADD_SIZE:0] FRAME_CNT = (ADD_SIZE+1)'(FRAME_WORDS);
    localparam logic [WDW-1:0]    WDOG_MAX  = WDW'(TIMEOUT_CYCLES);

    seq_state_t            state_q, state_d;
    logic [ADD_SIZE-1:0]   base_q, base_d;
    logic [ADD_SIZE:0]     cnt_q, cnt_d, cnt_inc;
    logic [WDW-1:0]        wdog_q, wdog_d, wdog_inc;
    logic                  terr_q, terr_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_flush;
    logic [DATA_SIZE-1:0]  fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;

    assign busy       = (state_q == ARMED) || (state_q == ISSUE) || (state_q == WAIT_ACK);
    assign res_ready  = busy && !fifo_full;
    assign fifo_push  = res_valid && res_ready;
    assign cnt_inc    = cnt_q + 1'b1;
    assign wdog_inc   = wdog_q + 1'b1;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_SIZE)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (fifo_push),
        .push_dat (res_data),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        wdog_d     = wdog_q;
        terr_d     = terr_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    cnt_d   = '0;
                    terr_d  = 1'b0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (fifo_count != '0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (wr_out_ready) begin
                    fifo_pop = 1'b1;
                    cnt_d    = cnt_inc;
                    state_d  = (cnt_inc == FRAME_CNT) ? DONE : ARMED;
                end else begin
                    wdog_d = wdog_inc;
                    // A stuck controller abandons the frame and drops any buffered words.
                    if (wdog_inc == WDOG_MAX) begin
                        terr_d     = 1'b1;
                        fifo_flush = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_in_valid = (state_q == ISSUE);
    assign wr_write_en = (state_q == ISSUE) || (state_q == WAIT_ACK);
    assign wr_address  = wr_write_en ? (base_q + cnt_q[ADD_SIZE-1:0]) : '0;
    assign wr_data     = (wr_write_en && !fifo_empty) ? fifo_head : '0;
    assign frame_done  = (state_q == DONE);
    assign timeout_err = terr_q;
    assign word_count  = cnt_q;

endmodule

// File: tb/tb_result_write_sequencer.sv
// Directed bench for result_write_sequencer: scoreboard model of the write stream plus literal spot checks.
module tb_result_write_sequencer;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int FW    = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic          wr_in_valid;
    logic          wr_write_en;
    logic [AW-1:0] wr_address;
    logic [DW-1:0] wr_data;
    logic          wr_out_ready;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;
    logic [AW:0]   word_count;

    result_write_sequencer #(
        .ADD_SIZE       (AW),
        .DATA_SIZE      (DW),
        .FIFO_DEPTH     (DEPTH),
        .FRAME_WORDS    (FW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready),
        .wr_in_valid  (wr_in_valid),
        .wr_write_en  (wr_write_en),
        .wr_address   (wr_address),
        .wr_data      (wr_data),
        .wr_out_ready (wr_out_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of what the block has promised: frame progress, buffered words, error flag.
    bit            m_active, m_done_now, m_terr, prev_we;
    logic [AW-1:0] m_base;
    int            m_cnt, m_wd;
    logic [DW-1:0] m_q[$];

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int            issue_cyc[$];
    int            wait_cnt, done_cnt, cyc, last_push_cyc;

    bit ctl_en, man_ack;
    int cd;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Controller stand-in: acknowledge 3 cycles after each ISSUE when enabled, or on demand.
    initial begin
        wr_out_ready = 1'b0;
        cd = 0;
        forever begin
            @(negedge clk);
            if (wr_in_valid) cd = 3;
            @(posedge clk);
            #2;
            if (cd == 1) begin
                cd = 0;
                wr_out_ready = ctl_en || man_ack;
            end else begin
                if (cd > 0) cd--;
                wr_out_ready = man_ack;
            end
        end
    end

    initial begin
        bit            exp_ready, was_active, flushed, nd;
        logic [AW-1:0] ea;
        m_active = 0; m_done_now = 0; m_terr = 0; m_cnt = 0; m_wd = 0; m_base = '0; prev_we = 0;
        wait_cnt = 0; done_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_outputs", {res_ready, wr_in_valid, wr_write_en, wr_address, wr_data,
                                      busy, frame_done, timeout_err, word_count}, 64'd0);
                m_active = 0; m_done_now = 0; m_terr = 0; m_cnt = 0; m_wd = 0; m_base = '0;
                m_q.delete();
                prev_we = 0;
            end else begin
                exp_ready = m_active && (m_q.size() < DEPTH);
                chk("busy", busy, m_active);
                chk("res_ready", res_ready, exp_ready);
                chk("frame_done", frame_done, m_done_now);
                chk("word_count", word_count, m_cnt);
                chk("timeout_err", timeout_err, m_terr);
                if (!m_active) chk("no_write_when_idle", {wr_in_valid, wr_write_en}, 2'b00);
                if (wr_write_en) begin
                    ea = m_base + AW'(m_cnt);
                    chk("wr_address", wr_address, ea);
                    chk("write_has_word", m_q.size() > 0, 1'b1);
                    if (m_q.size() > 0) chk("wr_data", wr_data, m_q[0]);
                end
                if (wr_in_valid) begin
                    chk("issue_write_en", wr_write_en, 1'b1);
                    chk("issue_single_cycle", prev_we, 1'b0);
                    log_addr.push_back(wr_address);
                    log_data.push_back(wr_data);
                    issue_cyc.push_back(cyc);
                    wait_cnt = 0;
                end
                if (wr_write_en && !wr_in_valid) begin
                    chk("wait_follows_issue", prev_we, 1'b1);
                    wait_cnt++;
                end
                if (frame_done) done_cnt++;

                was_active = m_active;
                flushed = 0;
                nd = 0;
                if (m_active && wr_write_en && !wr_in_valid) begin
                    if (wr_out_ready) begin
                        if (m_q.size() > 0) void'(m_q.pop_front());
                        m_cnt++;
                        if (m_cnt == FW) begin
                            m_active = 0;
                            nd = 1;
                        end
                    end else begin
                        m_wd++;
                        if (m_wd == TO) begin
                            m_terr = 1;
                            m_active = 0;
                            m_q.delete();
                            flushed = 1;
                        end
                    end
                end
                if (wr_in_valid) m_wd = 0;
                if (res_valid && exp_ready && !flushed) m_q.push_back(res_data);
                if (start && !was_active && !m_done_now) begin
                    m_active = 1;
                    m_base = base_addr;
                    m_cnt = 0;
                    m_terr = 0;
                    m_wd = 0;
                end
                m_done_now = nd;
                prev_we = wr_write_en;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
        base_addr = '0;
    endtask

    task automatic send(input logic [DW-1:0] w);
        bit ok;
        ok = 0;
        res_valid = 1'b1;
        res_data = w;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_ready) begin
                ok = 1;
                last_push_cyc = cyc;
                break;
            end
        end
        tick();
        res_valid = 1'b0;
        if (!ok) chk("send_accepted", 1'b0, 1'b1);
    endtask

    task automatic wait_done(input int lim);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1;
                break;
            end
        end
        chk("frame_done_seen", ok, 1'b1);
        tick();
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        issue_cyc.delete();
        done_cnt = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int            p0, acc;
        bit            ok;
        logic [AW-1:0] wrap_exp [4];
        wrap_exp = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        rst = 1'b0; start = 1'b0; base_addr = '0; res_valid = 1'b0; res_data = '0;
        ctl_en = 1; man_ack = 0; last_push_cyc = 0;
        repeat (3) tick();
        chk("reset_idle", {res_ready, wr_in_valid, wr_write_en, wr_address, wr_data,
                           busy, frame_done, timeout_err, word_count}, 64'd0);
        rst = 1'b1;
        tick(); tick();
        chk("ready_low_before_start", res_ready, 1'b0);

        // Basic frame
        clear_logs();
        do_start(11'h010);
        send(32'hA0);
        p0 = last_push_cyc;
        for (int i = 1; i < 4; i++) send(32'hA0 + i);
        wait_done(100);
        tick(); tick();
        chk("basic_n_writes", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk("basic_addr", log_addr[i], 11'h010 + i);
            chk("basic_data", log_data[i], 32'hA0 + i);
        end
        if (issue_cyc.size() >= 2) begin
            chk("basic_push_to_issue", issue_cyc[0] - p0, 2);
            chk("basic_word_period", issue_cyc[1] - issue_cyc[0], 5);
        end
        chk("basic_done_pulses", done_cnt, 1);
        chk("basic_word_count", word_count, 4);
        chk("basic_busy_low", busy, 1'b0);

        // Address wrap
        clear_logs();
        do_start(11'h7FE);
        for (int i = 0; i < 4; i++) send(32'hC0 + i);
        wait_done(100);
        chk("wrap_n_writes", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) chk("wrap_addr", log_addr[i], wrap_exp[i]);

        // Backpressure with a stalled controller
        clear_logs();
        ctl_en = 0;
        do_start(11'h020);
        acc = 0;
        res_valid = 1'b1;
        res_data = 32'hB0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_ready) acc++;
            @(posedge clk);
            #1;
            res_data = 32'hB0 + acc;
        end
        chk("bp_accepted", acc, 4);
        chk("bp_ready_low", res_ready, 1'b0);
        res_valid = 1'b0;
        ctl_en = 1;
        man_ack = 1;
        tick();
        man_ack = 0;
        wait_done(100);
        chk("bp_n_writes", log_data.size(), 4);
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            chk("bp_data", log_data[i], 32'hB0 + i);
            chk("bp_addr", log_addr[i], 11'h020 + i);
        end

        // Watchdog
        clear_logs();
        ctl_en = 0;
        do_start(11'h040);
        send(32'hD0); send(32'hD1); send(32'hD2);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (timeout_err) begin
                ok = 1;
                break;
            end
        end
        chk("wd_fired", ok, 1'b1);
        chk("wd_wait_cycles", wait_cnt, 16);
        chk("wd_busy_low", busy, 1'b0);
        chk("wd_no_write", wr_write_en, 1'b0);
        tick();
        ctl_en = 1;
        clear_logs();
        do_start(11'h050);
        chk("wd_cleared_by_start", timeout_err, 1'b0);
        for (int i = 0; i < 4; i++) send(32'hE0 + i);
        wait_done(100);
        chk("flush_n_writes", log_data.size(), 4);
        if (log_data.size() > 0) chk("flush_first_data", log_data[0], 32'hE0);

        // Ignored start and stray ack
        clear_logs();
        do_start(11'h060);
        send(32'hF0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (word_count == 1) begin
                ok = 1;
                break;
            end
        end
        chk("first_ack_seen", ok, 1'b1);
        tick();
        man_ack = 1;
        tick();
        man_ack = 0;
        tick(); tick();
        chk("stray_ack_count", word_count, 1);
        do_start(11'h100);
        chk("ignored_start_busy", busy, 1'b1);
        send(32'hF1);
        do_start(11'h100);
        send(32'hF2);
        send(32'hF3);
        wait_done(100);
        chk("ign_n_writes", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk("ign_addr", log_addr[i], 11'h060 + i);
            chk("ign_data", log_data[i], 32'hF0 + i);
        end

        // Reset mid-frame
        ctl_en = 0;
        do_start(11'h070);
        send(32'h55);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_write_en && !wr_in_valid) begin
                ok = 1;
                break;
            end
        end
        chk("reached_wait_ack", ok, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_midframe_outputs", {res_ready, wr_in_valid, wr_write_en, wr_address, wr_data,
                                       busy, frame_done, timeout_err, word_count}, 64'd0);
        tick(); tick();
        rst = 1'b1;
        ctl_en = 1;
        res_valid = 1'b1;
        res_data = 32'h77;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset_ready_low", res_ready, 1'b0);
        end
        res_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
